// File: rtl/core_pkg.sv
// Shared core types: RISC-V base opcodes, fetch FSM states and fetch-buffer entry layout.
package core_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned IMM_SRC_W = 25;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [OPCODE_W-1:0] {
        OP_LOAD     = 7'b000_0011,
        OP_MISC_MEM = 7'b000_1111,
        OP_IMM      = 7'b001_0011,
        OP_AUIPC    = 7'b001_0111,
        OP_STORE    = 7'b010_0011,
        OP_OP       = 7'b011_0011,
        OP_LUI      = 7'b011_0111,
        OP_BRANCH   = 7'b110_0011,
        OP_JALR     = 7'b110_0111,
        OP_JAL      = 7'b110_1111,
        OP_SYSTEM   = 7'b111_0011
    } opcode_t;

    typedef enum logic [1:0] {
        FS_RESET = 2'd0,
        FS_RUN   = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch queue: entries are allocated at request time and filled by responses in order.
module fetch_buffer
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               alloc,
    input  logic [ADDR_W-1:0]  alloc_pc,
    input  logic               fill,
    input  logic [INSTR_W-1:0] fill_data,
    input  logic               pop,
    output logic               head_valid,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [CNT_W-1:0]   alloc_cnt,
    output logic [CNT_W-1:0]   unfilled_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] tail_ptr;

    assign head_valid = entries[head_ptr].filled;
    assign head_pc    = entries[head_ptr].pc;
    assign head_instr = entries[head_ptr].instr;

    // Alloc, fill and pop always hit distinct slots, so they may all land in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries      <= '{default: '0};
            head_ptr     <= '0;
            fill_ptr     <= '0;
            tail_ptr     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[PTR_W'(i)].filled <= 1'b0;
            end
            head_ptr     <= '0;
            fill_ptr     <= '0;
            tail_ptr     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
        end else begin
            if (alloc) begin
                entries[tail_ptr].pc     <= alloc_pc;
                entries[tail_ptr].filled <= 1'b0;
                tail_ptr                 <= tail_ptr + PTR_W'(1);
            end
            if (fill) begin
                entries[fill_ptr].instr  <= fill_data;
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + PTR_W'(1);
            end
            if (pop) begin
                entries[head_ptr].filled <= 1'b0;
                head_ptr                 <= head_ptr + PTR_W'(1);
            end
            alloc_cnt    <= alloc_cnt + CNT_W'(alloc) - CNT_W'(pop);
            unfilled_cnt <= unfilled_cnt + CNT_W'(alloc) - CNT_W'(fill);
        end
    end

    // A response must always have an outstanding slot waiting for it.
    fill_has_slot: assert property (@(posedge clk) disable iff (!rst_n) fill |-> (unfilled_cnt != '0));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word fetches, buffers returns and feeds decode.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned       BUF_DEPTH = 2,
    parameter int unsigned       DROP_W    = $clog2(BUF_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [ADDR_W-1:0]    imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [INSTR_W-1:0]   imem_rsp_data,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_pc,
    input  logic                 dec_ready,
    output logic                 dec_valid,
    output logic [INSTR_W-1:0]   dec_instr,
    output logic [ADDR_W-1:0]    dec_pc,
    output logic [OPCODE_W-1:0]  dec_opcode,
    output logic [IMM_SRC_W-1:0] dec_imm_src
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [DROP_W-1:0] drop_cnt;
    logic [DROP_W-1:0] drop_next;
    logic [DROP_W-1:0] pend_cnt;

    logic               buf_alloc;
    logic               buf_fill;
    logic               buf_pop;
    logic               buf_flush;
    logic               head_valid;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [DROP_W-1:0]  alloc_cnt;
    logic [DROP_W-1:0]  unfilled_cnt;

    // Issue gating uses only registered occupancy: no path from dec_ready to the request.
    assign imem_req_valid = (state == FS_RUN) && (alloc_cnt < DROP_W'(BUF_DEPTH)) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign buf_alloc      = imem_req_valid && imem_req_ready;

    assign dec_valid   = head_valid && !redirect_valid;
    assign buf_pop     = dec_valid && dec_ready;
    assign dec_instr   = head_instr;
    assign dec_pc      = head_pc;
    assign dec_opcode  = head_instr[OPCODE_W-1:0];
    assign dec_imm_src = head_instr[INSTR_W-1:OPCODE_W];

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (DROP_W)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (buf_flush),
        .alloc        (buf_alloc),
        .alloc_pc     (pc),
        .fill         (buf_fill),
        .fill_data    (imem_rsp_data),
        .pop          (buf_pop),
        .head_valid   (head_valid),
        .head_pc      (head_pc),
        .head_instr   (head_instr),
        .alloc_cnt    (alloc_cnt),
        .unfilled_cnt (unfilled_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FS_RESET;
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            drop_cnt <= drop_next;
        end
    end

    // Redirect overrides every state; responses already in flight become drop credits.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        drop_next  = drop_cnt;
        buf_flush  = 1'b0;
        buf_fill   = 1'b0;
        pend_cnt   = unfilled_cnt + ((state == FS_DRAIN) ? drop_cnt : '0);

        if (redirect_valid) begin
            if (imem_rsp_valid && (pend_cnt != '0)) begin
                pend_cnt = pend_cnt - DROP_W'(1);
            end
            pc_next    = redirect_pc & 32'hFFFF_FFFC;
            buf_flush  = 1'b1;
            drop_next  = pend_cnt;
            state_next = (pend_cnt != '0) ? FS_DRAIN : FS_RUN;
        end else begin
            case (state)
                FS_RESET: state_next = FS_RUN;
                FS_RUN: begin
                    buf_fill = imem_rsp_valid;
                    if (buf_alloc) begin
                        pc_next = pc + ADDR_W'(4);
                    end
                end
                FS_DRAIN: begin
                    if (imem_rsp_valid && (drop_cnt != '0)) begin
                        drop_next = drop_cnt - DROP_W'(1);
                        if (drop_cnt == DROP_W'(1)) begin
                            state_next = FS_RUN;
                        end
                    end
                end
                default: state_next = FS_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a fixed-latency in-order memory model.
module tb_instr_fetch_unit;
    import core_pkg::*;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [24:0] dec_imm_src;

    logic        req_valid2;
    logic        req_ready2;
    logic [31:0] req_addr2;
    logic        rsp_valid2;
    logic [31:0] rsp_data2;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;
    logic        dec_ready2;
    logic        unused_dec_valid2;
    logic [31:0] unused_dec_instr2;
    logic [31:0] unused_dec_pc2;
    logic [6:0]  unused_dec_opcode2;
    logic [24:0] unused_dec_imm2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t mem_q[$];

    int checks;
    int errors;
    int cyc;
    int lat;
    int req_cnt;
    int pop_cnt;
    int n2;
    int p0;
    int r0;

    logic        drv_redirect;
    logic [31:0] drv_redirect_pc;
    logic        drv_dec_ready;
    logic        drv_req_ready;
    logic [31:0] exp_fetch_pc;
    logic [31:0] exp2_pc;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_opcode     (dec_opcode),
        .dec_imm_src    (dec_imm_src)
    );

    instr_fetch_unit #(.RESET_PC(RST_PC2)) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (req_valid2),
        .imem_req_ready (req_ready2),
        .imem_req_addr  (req_addr2),
        .imem_rsp_valid (rsp_valid2),
        .imem_rsp_data  (rsp_data2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .dec_ready      (dec_ready2),
        .dec_valid      (unused_dec_valid2),
        .dec_instr      (unused_dec_instr2),
        .dec_pc         (unused_dec_pc2),
        .dec_opcode     (unused_dec_opcode2),
        .dec_imm_src    (unused_dec_imm2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Second core's memory answers every accepted request one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsp_valid2 <= 1'b0;
        else        rsp_valid2 <= req_valid2 && req_ready2;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'd7 + 32'h0050_0093;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at negedge, then observe handshakes that the next posedge will take.
    task automatic tick();
        exp_t e;
        rsp_t r;
        @(negedge clk);
        cyc++;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        dec_ready      = drv_dec_ready;
        imem_req_ready = drv_req_ready;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            r = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = r.data;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            check_eq("req_addr", imem_req_addr, exp_fetch_pc);
            r.due  = cyc + lat;
            r.data = mem_word(imem_req_addr);
            mem_q.push_back(r);
            e.pc    = exp_fetch_pc;
            e.instr = mem_word(exp_fetch_pc);
            exp_q.push_back(e);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
            req_cnt++;
        end
        if (dec_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("dec_valid_no_entry", 32'(dec_valid), 32'd0);
            end else if (dec_ready) begin
                e = exp_q.pop_front();
                check_eq("dec_pc", dec_pc, e.pc);
                check_eq("dec_instr", dec_instr, e.instr);
                check_eq("dec_opcode", 32'(dec_opcode), 32'(e.instr[6:0]));
                check_eq("dec_imm_src", 32'(dec_imm_src), 32'(e.instr[31:7]));
                pop_cnt++;
            end
        end
        if (drv_redirect) begin
            check_eq("redirect_gate", {30'd0, dec_valid, imem_req_valid}, 32'd0);
            exp_q.delete();
            exp_fetch_pc = drv_redirect_pc & 32'hFFFF_FFFC;
        end
        if (req_valid2 && req_ready2 && n2 < 3) begin
            check_eq("wrap_addr", req_addr2, exp2_pc);
            exp2_pc = exp2_pc + 32'd4;
            n2++;
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must be at reset values immediately.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        #1;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_req_addr", imem_req_addr, RST_PC);
        check_eq("rst_dec_valid", 32'(dec_valid), 32'd0);
        check_eq("rst_dec_instr", dec_instr, 32'd0);
        check_eq("rst_dec_pc", dec_pc, 32'd0);
        check_eq("rst_dec_opcode", 32'(dec_opcode), 32'd0);
        check_eq("rst_dec_imm", 32'(dec_imm_src), 32'd0);
        mem_q.delete();
        exp_q.delete();
        exp_fetch_pc = RST_PC;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("release_req_valid", 32'(imem_req_valid), 32'd0);
    endtask

    task automatic wait_dec(input string tag, input int budget);
        int n;
        n = 0;
        while (!dec_valid && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(dec_valid), 32'd1);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; lat = 1;
        req_cnt = 0; pop_cnt = 0; n2 = 0; p0 = 0; r0 = 0;
        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; dec_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        drv_redirect = 1'b0; drv_redirect_pc = 32'd0;
        drv_dec_ready = 1'b1; drv_req_ready = 1'b1;
        exp_fetch_pc = RST_PC; exp2_pc = RST_PC2;
        req_ready2 = 1'b1; rsp_data2 = 32'h0000_0013;
        redirect_valid2 = 1'b0; redirect_pc2 = 32'd0; dec_ready2 = 1'b1;

        // Latency 1, decode always ready.
        do_reset();
        wait_dec("a_first_timeout", 10);
        check_eq("a_first_pc", dec_pc, 32'h0);
        check_eq("a_first_instr", dec_instr, 32'h0050_0093);
        check_eq("a_first_opcode", 32'(dec_opcode), 32'h13);
        check_eq("a_first_imm", 32'(dec_imm_src), 32'h0000_A001);
        repeat (9) tick();
        p0 = pop_cnt;
        repeat (12) tick();
        // Each of the two slots turns over every 3 cycles (issue, fill, pop).
        check_eq("a_throughput", 32'(pop_cnt - p0), 32'd8);

        // Decode stalled: only BUF_DEPTH requests go out.
        drv_dec_ready = 1'b0;
        do_reset();
        r0 = req_cnt;
        repeat (8) tick();
        check_eq("b_req_count", 32'(req_cnt - r0), 32'd2);
        check_eq("b_req_idle", 32'(imem_req_valid), 32'd0);
        check_eq("b_head_valid", 32'(dec_valid), 32'd1);
        check_eq("b_head_pc", dec_pc, 32'h0);
        drv_dec_ready = 1'b1;
        p0 = pop_cnt;
        repeat (10) tick();
        check_eq("b_resume_pops", 32'(pop_cnt - p0 >= 2), 32'd1);

        // Reset with a full queue, then refetch from RESET_PC.
        drv_dec_ready = 1'b0;
        repeat (6) tick();
        check_eq("r_full_valid", 32'(dec_valid), 32'd1);
        do_reset();
        drv_dec_ready = 1'b1;
        wait_dec("r_refetch_timeout", 10);
        check_eq("r_refetch_pc", dec_pc, RST_PC);

        // Latency 3, redirect with two fetches outstanding.
        lat = 3;
        do_reset();
        r0 = req_cnt;
        tick();
        tick();
        check_eq("c_outstanding", 32'(req_cnt - r0), 32'd2);
        drv_redirect = 1'b1; drv_redirect_pc = 32'h0000_0103;
        tick();
        drv_redirect = 1'b0;
        tick();
        check_eq("c_state_drain", 32'(dut.state), 32'(FS_DRAIN));
        check_eq("c_drain_req", 32'(imem_req_valid), 32'd0);
        check_eq("c_drain_dec", 32'(dec_valid), 32'd0);
        tick();
        check_eq("c_drain_req2", 32'(imem_req_valid), 32'd0);
        tick();
        check_eq("c_resume_valid", 32'(imem_req_valid), 32'd1);
        check_eq("c_resume_addr", imem_req_addr, 32'h0000_0100);
        wait_dec("c_first_timeout", 20);
        check_eq("c_first_pc", dec_pc, 32'h0000_0100);

        // Second redirect during drain, coinciding with a stale response.
        do_reset();
        tick();
        tick();
        drv_redirect = 1'b1; drv_redirect_pc = 32'h0000_0300;
        tick();
        drv_redirect_pc = 32'h0000_0200;
        tick();
        check_eq("d_rsp_with_redirect", 32'(imem_rsp_valid), 32'd1);
        drv_redirect = 1'b0;
        tick();
        check_eq("d_drop_cnt", 32'(dut.drop_cnt), 32'd1);
        check_eq("d_state_drain", 32'(dut.state), 32'(FS_DRAIN));
        check_eq("d_drain_req", 32'(imem_req_valid), 32'd0);
        tick();
        check_eq("d_resume_valid", 32'(imem_req_valid), 32'd1);
        check_eq("d_resume_addr", imem_req_addr, 32'h0000_0200);
        wait_dec("d_first_timeout", 20);
        check_eq("d_first_pc", dec_pc, 32'h0000_0200);
        repeat (6) tick();

        check_eq("wrap_seen", 32'(n2), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
